// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG block serializer slice.
// Pixel/geometry defaults and scan-mode encoding.
package jpeg_pkg;

    localparam int PIX_W_DEF   = 8;
    localparam int BLK_DIM_DEF = 8;

    typedef enum logic {
        SCAN_RASTER    = 1'b0,
        SCAN_TRANSPOSE = 1'b1
    } scan_e;

    function automatic int idx_width(input int blk_dim);
        return $clog2(blk_dim * blk_dim);
    endfunction

endpackage

// File: rtl/jpeg_block_serializer_pp_if.sv
// Block-in / pixel-out handshake bundle for the serializer.
// master = block source and pixel sink, slave = serializer.
interface jpeg_block_serializer_pp_if
    import jpeg_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int BLK_DIM = BLK_DIM_DEF
) ();

    localparam int BLK_PIX = BLK_DIM * BLK_DIM;
    localparam int IDX_W   = idx_width(BLK_DIM);

    logic                     blk_valid;
    logic                     blk_ready;
    logic [BLK_PIX*PIX_W-1:0] blk_data;
    logic                     blk_transpose;

    logic                     pix_valid;
    logic                     pix_ready;
    logic [PIX_W-1:0]         pix_data;
    logic [IDX_W-1:0]         pix_idx;
    logic                     pix_first;
    logic                     pix_last;

    logic                     block_done;
    logic [1:0]               occupancy;

    modport master (
        output blk_valid, blk_data, blk_transpose, pix_ready,
        input  blk_ready, pix_valid, pix_data, pix_idx,
        input  pix_first, pix_last, block_done, occupancy
    );

    modport slave (
        input  blk_valid, blk_data, blk_transpose, pix_ready,
        output blk_ready, pix_valid, pix_data, pix_idx,
        output pix_first, pix_last, block_done, occupancy
    );

endinterface

// File: rtl/jpeg_block_index_gen.sv
// Scan position to block element address (raster or column-major).
// Row and column are plain bit fields of k, so transpose is a field swap.
module jpeg_block_index_gen #(
    parameter int BLK_DIM = 8
) (
    k_i,
    transpose_i,
    addr_o
);

    localparam int LOG_DIM = $clog2(BLK_DIM);
    localparam int IDX_W   = 2 * LOG_DIM;

    input  logic [IDX_W-1:0] k_i;
    input  logic             transpose_i;
    output logic [IDX_W-1:0] addr_o;

    logic [LOG_DIM-1:0] row;
    logic [LOG_DIM-1:0] col;

    assign row    = k_i[IDX_W-1:LOG_DIM];
    assign col    = k_i[LOG_DIM-1:0];
    assign addr_o = transpose_i ? {col, row} : k_i;

endmodule

// File: rtl/jpeg_block_serializer_pp.sv
// Double-buffered block-to-pixel serializer: two block slots in
// ping-pong, one pixel per transfer, raster or transposed scan.
module jpeg_block_serializer_pp
    import jpeg_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int BLK_DIM = BLK_DIM_DEF
) (
    input logic                       clk,
    input logic                       rst,
    jpeg_block_serializer_pp_if.slave bus
);

    localparam int               BLK_PIX = BLK_DIM * BLK_DIM;
    localparam int               IDX_W   = idx_width(BLK_DIM);
    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(BLK_PIX - 1);

    logic [BLK_PIX-1:0][PIX_W-1:0] slot_q [2];
    scan_e                         mode_q [2];

    logic [1:0]       count_q, count_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             done_q, done_d;

    logic             accept;
    logic             xfer;
    logic             free;
    logic [IDX_W-1:0] addr;

    // Ready depends on count only, never on the pixel side.
    assign bus.blk_ready = !rst && (count_q != 2'd2);
    assign bus.pix_valid = (count_q != 2'd0);

    assign accept = bus.blk_valid && bus.blk_ready;
    assign xfer   = bus.pix_valid && bus.pix_ready;
    assign free   = xfer && (k_q == K_LAST);

    always_comb begin
        count_d = count_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        k_d     = k_q;
        done_d  = free;
        if (accept) begin
            wr_d = ~wr_q;
        end
        if (xfer) begin
            k_d = k_q + 1'b1;
        end
        if (free) begin
            rd_d = ~rd_q;
        end
        unique case ({accept, free})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[wr_q] <= bus.blk_data;
            mode_q[wr_q] <= scan_e'(bus.blk_transpose);
        end
    end

    jpeg_block_index_gen #(
        .BLK_DIM (BLK_DIM)
    ) u_idx (
        .k_i         (k_q),
        .transpose_i (mode_q[rd_q] == SCAN_TRANSPOSE),
        .addr_o      (addr)
    );

    assign bus.pix_data   = slot_q[rd_q][addr];
    assign bus.pix_idx    = k_q;
    assign bus.pix_first  = (k_q == '0);
    assign bus.pix_last   = (k_q == K_LAST);
    assign bus.block_done = done_q;
    assign bus.occupancy  = count_q;

endmodule

// File: tb/tb_jpeg_block_serializer_pp.sv
// Directed and randomised bench for the ping-pong block serializer,
// covering an 8x8/8-bit instance and a 4x4/12-bit instance.
module tb_jpeg_block_serializer_pp;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    jpeg_block_serializer_pp_if #(.PIX_W(8),  .BLK_DIM(8)) b8 ();
    jpeg_block_serializer_pp_if #(.PIX_W(12), .BLK_DIM(4)) b4 ();

    jpeg_block_serializer_pp #(.PIX_W(8), .BLK_DIM(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    jpeg_block_serializer_pp #(.PIX_W(12), .BLK_DIM(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    function automatic logic [511:0] mk8(input int base);
        logic [511:0] v;
        for (int e = 0; e < 64; e++) v[e*8 +: 8] = 8'(base + e);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        b8.blk_valid = 0; b8.blk_data = '0; b8.blk_transpose = 0; b8.pix_ready = 0;
        b4.blk_valid = 0; b4.blk_data = '0; b4.blk_transpose = 0; b4.pix_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (b8.blk_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_in_rst: got %b want 0", b8.blk_ready);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b8.pix_valid !== 1'b0 || b8.occupancy !== 2'd0 || b8.block_done !== 1'b0) begin
            n_err++; $display("FAIL reset_state8: got v=%b occ=%0d done=%b want 0/0/0",
                              b8.pix_valid, b8.occupancy, b8.block_done);
        end
        n_cmp++;
        if (b8.blk_ready !== 1'b1 || b4.blk_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_after: got %b/%b want 1/1",
                              b8.blk_ready, b4.blk_ready);
        end
        n_cmp++;
        if (b4.pix_valid !== 1'b0 || b4.occupancy !== 2'd0) begin
            n_err++; $display("FAIL reset_state4: got v=%b occ=%0d want 0/0",
                              b4.pix_valid, b4.occupancy);
        end
    endtask

    task automatic test_stream(input int base, input logic tr);
        logic [7:0] e;
        int r, c;
        @(posedge clk); #1;
        b8.blk_valid = 1; b8.blk_data = mk8(base); b8.blk_transpose = tr; b8.pix_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (b8.blk_ready !== 1'b1) begin
            n_err++; $display("FAIL stream_accept: got ready=%b want 1", b8.blk_ready);
        end
        @(posedge clk); #1; b8.blk_valid = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            r = k / 8; c = k % 8;
            e = 8'(base + (tr ? c * 8 + r : k));
            n_cmp++;
            if (b8.pix_valid !== 1'b1 || b8.pix_data !== e || b8.pix_idx !== 6'(k) ||
                b8.pix_first !== (k == 0) || b8.pix_last !== (k == 63) ||
                b8.block_done !== 1'b0) begin
                n_err++;
                $display("FAIL stream tr=%0d k=%0d: got v=%b d=%0d i=%0d f=%b l=%b dn=%b want d=%0d",
                         tr, k, b8.pix_valid, b8.pix_data, b8.pix_idx, b8.pix_first,
                         b8.pix_last, b8.block_done, e);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (b8.block_done !== 1'b1 || b8.pix_valid !== 1'b0 || b8.occupancy !== 2'd0) begin
            n_err++; $display("FAIL stream_done: got dn=%b v=%b occ=%0d want 1/0/0",
                              b8.block_done, b8.pix_valid, b8.occupancy);
        end
        @(negedge clk);
        n_cmp++;
        if (b8.block_done !== 1'b0) begin
            n_err++; $display("FAIL stream_done_pulse: got %b want 0", b8.block_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        @(posedge clk); #1;
        b8.blk_valid = 1; b8.blk_data = mk8(0); b8.blk_transpose = 0; b8.pix_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (b8.blk_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready_a: got %b want 1", b8.blk_ready);
        end
        @(posedge clk); #1; b8.blk_data = mk8(100);
        @(negedge clk);
        n_cmp++;
        if (b8.blk_ready !== 1'b1 || b8.pix_data !== 8'd0 || b8.pix_idx !== 6'd0) begin
            n_err++; $display("FAIL b2b_ready_b: got rdy=%b d=%0d i=%0d want 1/0/0",
                              b8.blk_ready, b8.pix_data, b8.pix_idx);
        end
        @(posedge clk); #1; b8.blk_valid = 0;
        for (int i = 1; i < 128; i++) begin
            @(negedge clk);
            e = (i < 64) ? 8'(i) : 8'(100 + i - 64);
            n_cmp++;
            if (b8.pix_valid !== 1'b1 || b8.pix_data !== e ||
                b8.block_done !== (i == 64)) begin
                n_err++; $display("FAIL b2b i=%0d: got v=%b d=%0d dn=%b want 1/%0d/%b",
                                  i, b8.pix_valid, b8.pix_data, b8.block_done, e, i == 64);
            end
            if (i == 1) begin
                n_cmp++;
                if (b8.occupancy !== 2'd2 || b8.blk_ready !== 1'b0) begin
                    n_err++; $display("FAIL b2b_full: got occ=%0d rdy=%b want 2/0",
                                      b8.occupancy, b8.blk_ready);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (b8.block_done !== 1'b1 || b8.pix_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_done2: got dn=%b v=%b want 1/0",
                              b8.block_done, b8.pix_valid);
        end
    endtask

    task automatic test_stall_overflow();
        int nblk = 0, nx = 0, stall = 0, base;
        logic acc, xf;
        logic [7:0] e;
        @(posedge clk); #1;
        b8.blk_valid = 1; b8.blk_data = mk8(0); b8.blk_transpose = 0; b8.pix_ready = 1;
        for (int cyc = 0; cyc < 400 && nx < 192; cyc++) begin
            @(negedge clk);
            acc = b8.blk_valid && b8.blk_ready;
            xf  = b8.pix_valid && b8.pix_ready;
            if (xf) begin
                base = (nx < 64) ? 0 : (nx < 128) ? 100 : 170;
                e = 8'(base + nx % 64);
                n_cmp++;
                if (b8.pix_data !== e || b8.pix_idx !== 6'(nx % 64)) begin
                    n_err++; $display("FAIL stall_seq n=%0d: got d=%0d i=%0d want %0d/%0d",
                                      nx, b8.pix_data, b8.pix_idx, e, nx % 64);
                end
            end
            if (!b8.pix_ready) begin
                n_cmp++;
                if (b8.pix_valid !== 1'b1 || b8.pix_data !== 8'd10 || b8.pix_idx !== 6'd10) begin
                    n_err++; $display("FAIL stall_hold: got v=%b d=%0d i=%0d want 1/10/10",
                                      b8.pix_valid, b8.pix_data, b8.pix_idx);
                end
                n_cmp++;
                if (b8.blk_ready !== 1'b0 || b8.occupancy !== 2'd2) begin
                    n_err++; $display("FAIL stall_full: got rdy=%b occ=%0d want 0/2",
                                      b8.blk_ready, b8.occupancy);
                end
            end
            @(posedge clk); #1;
            if (xf) nx++;
            if (acc) begin
                nblk++;
                if (nblk == 1) b8.blk_data = mk8(100);
                else b8.blk_valid = 0;
            end
            if (nx == 10 && stall < 10) begin
                b8.pix_ready = 0;
                stall++;
                if (stall == 1) begin
                    b8.blk_valid = 1; b8.blk_data = mk8(170);
                end
            end else begin
                b8.pix_ready = 1;
            end
        end
        n_cmp++;
        if (nx != 192 || nblk != 3) begin
            n_err++; $display("FAIL stall_total: got xfers=%0d blocks=%0d want 192/3", nx, nblk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int nblk = 0, nx = 0;
        logic acc, xf;
        @(posedge clk); #1;
        b8.blk_valid = 1; b8.blk_data = mk8(0); b8.blk_transpose = 0; b8.pix_ready = 1;
        for (int cyc = 0; cyc < 100 && nx < 30; cyc++) begin
            @(negedge clk);
            acc = b8.blk_valid && b8.blk_ready;
            xf  = b8.pix_valid && b8.pix_ready;
            @(posedge clk); #1;
            if (xf) nx++;
            if (acc) begin
                nblk++;
                if (nblk == 1) b8.blk_data = mk8(100);
                else b8.blk_valid = 0;
            end
        end
        n_cmp++;
        if (b8.pix_idx !== 6'd30 || b8.occupancy !== 2'd2) begin
            n_err++; $display("FAIL rstmid_pre: got i=%0d occ=%0d want 30/2",
                              b8.pix_idx, b8.occupancy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b8.blk_ready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ready_in_rst: got %b want 0", b8.blk_ready);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b8.pix_valid !== 1'b0 || b8.occupancy !== 2'd0 ||
            b8.blk_ready !== 1'b1 || b8.block_done !== 1'b0) begin
            n_err++; $display("FAIL rstmid_post: got v=%b occ=%0d rdy=%b dn=%b want 0/0/1/0",
                              b8.pix_valid, b8.occupancy, b8.blk_ready, b8.block_done);
        end
        @(negedge clk);
        n_cmp++;
        if (b8.block_done !== 1'b0 || b8.pix_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_quiet: got dn=%b v=%b want 0/0",
                              b8.block_done, b8.pix_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0]   q8[$];
        logic [11:0]  q4[$];
        logic [511:0] blk8;
        logic [191:0] blk4;
        int  k8 = 0, k4 = 0, c8 = 0, c4 = 0, e, cyc = 0;
        logic acc8, xf8, fr8, de8 = 0, acc4, xf4, fr4, de4 = 0;
        while (cyc < 1500 && (cyc < 500 || q8.size() != 0 || q4.size() != 0 ||
                              b8.blk_valid || b4.blk_valid)) begin
            @(negedge clk);
            acc8 = b8.blk_valid && b8.blk_ready;
            xf8  = b8.pix_valid && b8.pix_ready;
            acc4 = b4.blk_valid && b4.blk_ready;
            xf4  = b4.pix_valid && b4.pix_ready;
            fr8 = 0; fr4 = 0;
            n_cmp++;
            if (b8.occupancy !== 2'(c8) || b8.pix_valid !== (c8 > 0) ||
                b8.blk_ready !== (c8 < 2) || b8.block_done !== de8) begin
                n_err++; $display("FAIL rand8_ctl cyc=%0d: got occ=%0d v=%b r=%b dn=%b want %0d/%b",
                                  cyc, b8.occupancy, b8.pix_valid, b8.blk_ready, b8.block_done, c8, de8);
            end
            n_cmp++;
            if (b4.occupancy !== 2'(c4) || b4.pix_valid !== (c4 > 0) ||
                b4.blk_ready !== (c4 < 2) || b4.block_done !== de4) begin
                n_err++; $display("FAIL rand4_ctl cyc=%0d: got occ=%0d v=%b r=%b dn=%b want %0d/%b",
                                  cyc, b4.occupancy, b4.pix_valid, b4.blk_ready, b4.block_done, c4, de4);
            end
            if (xf8) begin
                n_cmp++;
                if (q8.size() == 0 || b8.pix_data !== q8[0] || b8.pix_idx !== 6'(k8) ||
                    b8.pix_first !== (k8 == 0) || b8.pix_last !== (k8 == 63)) begin
                    n_err++; $display("FAIL rand8_pix k=%0d: got d=%0d i=%0d want d=%0d",
                                      k8, b8.pix_data, b8.pix_idx, q8.size() ? q8[0] : 8'd0);
                end
                if (q8.size() != 0) void'(q8.pop_front());
                fr8 = (k8 == 63);
                k8 = (k8 + 1) % 64;
            end
            if (xf4) begin
                n_cmp++;
                if (q4.size() == 0 || b4.pix_data !== q4[0] || b4.pix_idx !== 4'(k4) ||
                    b4.pix_first !== (k4 == 0) || b4.pix_last !== (k4 == 15)) begin
                    n_err++; $display("FAIL rand4_pix k=%0d: got d=%0d i=%0d want d=%0d",
                                      k4, b4.pix_data, b4.pix_idx, q4.size() ? q4[0] : 12'd0);
                end
                if (q4.size() != 0) void'(q4.pop_front());
                fr4 = (k4 == 15);
                k4 = (k4 + 1) % 16;
            end
            if (acc8) begin
                for (int k = 0; k < 64; k++) begin
                    e = b8.blk_transpose ? (k % 8) * 8 + k / 8 : k;
                    q8.push_back(blk8[e*8 +: 8]);
                end
            end
            if (acc4) begin
                for (int k = 0; k < 16; k++) begin
                    e = b4.blk_transpose ? (k % 4) * 4 + k / 4 : k;
                    q4.push_back(blk4[e*12 +: 12]);
                end
            end
            c8 = c8 + int'(acc8) - int'(fr8);
            c4 = c4 + int'(acc4) - int'(fr4);
            de8 = fr8; de4 = fr4;
            @(posedge clk); #1;
            if (acc8) b8.blk_valid = 0;
            if (acc4) b4.blk_valid = 0;
            if (!b8.blk_valid && cyc < 500 && $urandom_range(0, 1) == 1) begin
                for (int w = 0; w < 16; w++) blk8[w*32 +: 32] = $urandom();
                b8.blk_data = blk8; b8.blk_transpose = 1'($urandom_range(0, 1)); b8.blk_valid = 1;
            end
            if (!b4.blk_valid && cyc < 500 && $urandom_range(0, 2) == 0) begin
                for (int w = 0; w < 6; w++) blk4[w*32 +: 32] = $urandom();
                b4.blk_data = blk4; b4.blk_transpose = 1'($urandom_range(0, 1)); b4.blk_valid = 1;
            end
            b8.pix_ready = (cyc >= 500) || ($urandom_range(0, 9) < 7);
            b4.pix_ready = (cyc >= 500) || ($urandom_range(0, 9) < 5);
            cyc++;
        end
        n_cmp++;
        if (q8.size() != 0 || q4.size() != 0) begin
            n_err++; $display("FAIL rand_drain: got left8=%0d left4=%0d want 0/0",
                              q8.size(), q4.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream(0, 1'b0);
        test_stream(0, 1'b1);
        test_back_to_back();
        test_stall_overflow();
        test_reset_mid();
        test_stream(20, 1'b1);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
